// File: rtl/viterbi_pkg.sv
// Shared types and default constants for the Viterbi link BER monitor.
// No timing and no flow control: declarations only.
package viterbi_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } ber_state_t;

  localparam int BER_LAG_W      = 12;
  localparam int BER_WIN        = 64;
  localparam int BER_LOCK_ERR   = 2;
  localparam int BER_UNLOCK_ERR = 8;
  localparam int BER_CNT_W      = 32;

endpackage

// File: rtl/ber_delay_ram.sv
// Circular reference-bit delay line: writes at wp and registers the bit from lag_i samples back.
// Read latency is one enabled write; with we_i low the read register and pointer hold.
module ber_delay_ram #(
  parameter int LAG_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic             clr_i,
  input  logic             bit_i,
  input  logic [LAG_W-1:0] lag_i,
  output logic             bit_o
);

  localparam logic [LAG_W-1:0] WP_ONE = LAG_W'(1);

  logic             mem_q [2**LAG_W];
  logic [LAG_W-1:0] wp_q;
  logic [LAG_W-1:0] rd_addr;
  logic             rd_q;

  assign rd_addr = wp_q - lag_i;
  assign bit_o   = rd_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wp_q] <= bit_i;
  end

  // A zero lag bypasses the array so the current sample compares with itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q <= '0;
      rd_q <= 1'b0;
    end else if (clr_i) begin
      wp_q <= '0;
      rd_q <= 1'b0;
    end else if (we_i) begin
      wp_q <= wp_q + WP_ONE;
      rd_q <= (lag_i == '0) ? bit_i : mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/viterbi_ber_monitor.sv
// Decoder BER monitor: hunts the decoder lag, locks on a clean window, then counts bits and errors.
// Compares resolve one enabled sample after capture; enable_i=0 freezes all state, no backpressure.
module viterbi_ber_monitor
  import viterbi_pkg::*;
#(
  parameter int LAG_W      = BER_LAG_W,
  parameter int WIN        = BER_WIN,
  parameter int LOCK_ERR   = BER_LOCK_ERR,
  parameter int UNLOCK_ERR = BER_UNLOCK_ERR,
  parameter int CNT_W      = BER_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             ref_i,
  input  logic             dec_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic [LAG_W-1:0] lag_o,
  output logic [CNT_W-1:0] bit_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [7:0]       loss_cnt_o
);

  localparam int WW = $clog2(WIN);
  localparam int EW = $clog2(UNLOCK_ERR + 2);
  localparam logic [WW-1:0]    WIN_LAST = WW'(WIN - 1);
  localparam logic [WW-1:0]    WIN_ONE  = WW'(1);
  localparam logic [EW-1:0]    LOCK_E   = EW'(LOCK_ERR);
  localparam logic [EW-1:0]    UNLOCK_E = EW'(UNLOCK_ERR);
  localparam logic [EW-1:0]    ERR_SAT  = EW'(UNLOCK_ERR + 1);
  localparam logic [LAG_W:0]   FILL_MAX = {1'b1, {LAG_W{1'b0}}};
  localparam logic [LAG_W:0]   FILL_ONE = (LAG_W+1)'(1);
  localparam logic [LAG_W-1:0] LAG_ONE  = LAG_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ber_state_t       state_q, state_d;
  logic [LAG_W-1:0] lag_q, lag_d;
  logic [LAG_W:0]   fill_q;
  logic [WW-1:0]    win_cnt_q;
  logic [EW-1:0]    win_err_q, err_tot;
  logic             pv_q, dec_q, ref_dly;
  logic [CNT_W-1:0] bit_cnt_q, err_cnt_q;
  logic [7:0]       loss_cnt_q;
  logic             smp, eval, mis, win_last, stat_inc, loss_inc;

  assign smp      = enable_i & ~clear_i;
  assign eval     = smp & pv_q;
  assign mis      = ref_dly ^ dec_q;
  assign win_last = eval && (win_cnt_q == WIN_LAST);
  assign err_tot  = (win_err_q == ERR_SAT) ? ERR_SAT : win_err_q + EW'(mis);

  // Reading at the next lag keeps windows back to back across a lag step.
  ber_delay_ram #(.LAG_W(LAG_W)) u_dly (
    .clk   (clk),
    .rst   (rst),
    .we_i  (smp),
    .clr_i (clear_i),
    .bit_i (ref_i),
    .lag_i (lag_d),
    .bit_o (ref_dly)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SEARCH;
      lag_q   <= '0;
    end else begin
      state_q <= state_d;
      lag_q   <= lag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lag_d   = lag_q;
    if (clear_i) begin
      state_d = SEARCH;
      lag_d   = '0;
    end else if (win_last) begin
      case (state_q)
        SEARCH: begin
          if (err_tot <= LOCK_E) state_d = LOCKED;
          else                   lag_d   = lag_q + LAG_ONE;
        end
        LOCKED: begin
          if (err_tot > UNLOCK_E) state_d = SEARCH;
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked_o = (state_q == LOCKED);
    stat_inc = eval && (state_q == LOCKED);
    loss_inc = win_last && (state_q == LOCKED) && (state_d == SEARCH);
  end

  // A sample only counts once the buffer holds its lagged reference.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_q    <= '0;
      pv_q      <= 1'b0;
      dec_q     <= 1'b0;
      win_cnt_q <= '0;
      win_err_q <= '0;
    end else if (clear_i) begin
      fill_q    <= '0;
      pv_q      <= 1'b0;
      dec_q     <= 1'b0;
      win_cnt_q <= '0;
      win_err_q <= '0;
    end else if (smp) begin
      if (fill_q != FILL_MAX) fill_q <= fill_q + FILL_ONE;
      pv_q  <= (fill_q >= {1'b0, lag_d});
      dec_q <= dec_i;
      if (win_last) begin
        win_cnt_q <= '0;
        win_err_q <= '0;
      end else if (eval) begin
        win_cnt_q <= win_cnt_q + WIN_ONE;
        win_err_q <= err_tot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      loss_cnt_q <= '0;
    end else if (clear_i) begin
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      loss_cnt_q <= '0;
    end else begin
      if (stat_inc) begin
        if (bit_cnt_q != '1)         bit_cnt_q <= bit_cnt_q + CNT_ONE;
        if (mis && err_cnt_q != '1)  err_cnt_q <= err_cnt_q + CNT_ONE;
      end
      if (loss_inc && loss_cnt_q != 8'hFF) loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign lag_o      = lag_q;
  assign bit_cnt_o  = bit_cnt_q;
  assign err_cnt_o  = err_cnt_q;
  assign loss_cnt_o = loss_cnt_q;

endmodule

// File: tb/tb_viterbi_ber_monitor.sv
// Directed bench for viterbi_ber_monitor: lag search, lock, error counting, lock loss, clear and reset.
module tb_viterbi_ber_monitor;

  localparam int LAG_W = 12;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable_i = 1'b0;
  logic             ref_i = 1'b0;
  logic             dec_i = 1'b0;
  logic             clear_i = 1'b0;
  logic             locked_o;
  logic [LAG_W-1:0] lag_o;
  logic [CNT_W-1:0] bit_cnt_o;
  logic [CNT_W-1:0] err_cnt_o;
  logic [7:0]       loss_cnt_o;

  int           n_chk = 0;
  int           n_fail = 0;
  logic [6:0]   lfsr;
  logic [127:0] hist;
  int           smp_n;

  always #5 clk = ~clk;

  viterbi_ber_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .enable_i   (enable_i),
    .ref_i      (ref_i),
    .dec_i      (dec_i),
    .clear_i    (clear_i),
    .locked_o   (locked_o),
    .lag_o      (lag_o),
    .bit_cnt_o  (bit_cnt_o),
    .err_cnt_o  (err_cnt_o),
    .loss_cnt_o (loss_cnt_o)
  );

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic r, input logic d);
    enable_i = en;
    ref_i    = r;
    dec_i    = d;
    @(posedge clk);
    #1;
  endtask

  // PRBS-7 reference; decoded stream is the reference delayed 37 samples.
  task automatic prbs_smp(input logic flip);
    logic b;
    b = lfsr[6] ^ lfsr[5];
    lfsr = {lfsr[5:0], b};
    step(1'b1, b, hist[36] ^ flip);
    hist = {hist[126:0], b};
    smp_n++;
  endtask

  task automatic prbs_reset();
    lfsr  = 7'h01;
    hist  = '0;
    smp_n = 0;
  endtask

  initial begin
    int cyc;
    logic [31:0] b0, e0, b1;
    logic rb;

    // Reset state
    #22;
    chk_eq("rst_locked", locked_o, 0);
    chk_eq("rst_lag", lag_o, 0);
    chk_eq("rst_bits", bit_cnt_o, 0);
    chk_eq("rst_errs", err_cnt_o, 0);
    chk_eq("rst_loss", loss_cnt_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Identical streams lock at lag 0 after 64 samples plus one cycle
    for (int i = 0; i < 64; i++) begin
      rb = 1'($urandom_range(0, 1));
      step(1'b1, rb, rb);
    end
    chk_eq("t1_prelock", locked_o, 0);
    rb = 1'($urandom_range(0, 1));
    step(1'b1, rb, rb);
    chk_eq("t1_lock", locked_o, 1);
    chk_eq("t1_lag", lag_o, 0);
    chk_eq("t1_bits_at_lock", bit_cnt_o, 0);
    for (int i = 0; i < 10; i++) begin
      rb = 1'($urandom_range(0, 1));
      step(1'b1, rb, rb);
    end
    chk_eq("t1_bits", bit_cnt_o, 10);
    chk_eq("t1_errs", err_cnt_o, 0);

    // PRBS-7 with 37-sample lag
    clear_i = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    clear_i = 1'b0;
    chk_eq("clr_lag", lag_o, 0);
    chk_eq("clr_bits", bit_cnt_o, 0);
    prbs_reset();
    cyc = 0;
    while (!locked_o && cyc < 38 * 64 + 2) begin
      prbs_smp(1'b0);
      cyc++;
      if (cyc == 65) chk_eq("t2_lag_step", lag_o, 1);
    end
    chk_eq("t2_lock", locked_o, 1);
    chk_eq("t2_lag", lag_o, 37);
    chk_eq("t2_lock_time", cyc, 2433);
    chk_eq("t2_errs", err_cnt_o, 0);

    // Sparse errors: one every 100 samples
    b0 = bit_cnt_o;
    e0 = err_cnt_o;
    for (int j = 0; j < 1000; j++) prbs_smp((j % 100) == 50);
    chk_eq("t3_locked", locked_o, 1);
    chk_eq("t3_errs", err_cnt_o - e0, 10);
    chk_eq("t3_bits", bit_cnt_o - b0, 1000);

    // Nine consecutive errors inside one window force lock loss
    while (smp_n % 64 != 0) prbs_smp(1'b0);
    b0 = bit_cnt_o;
    e0 = err_cnt_o;
    for (int j = 0; j < 64; j++) prbs_smp(j >= 10 && j < 19);
    chk_eq("t4_hold", locked_o, 1);
    prbs_smp(1'b0);
    chk_eq("t4_unlock", locked_o, 0);
    chk_eq("t4_loss", loss_cnt_o, 1);
    chk_eq("t4_lag_kept", lag_o, 37);
    chk_eq("t4_errs", err_cnt_o - e0, 9);
    b1 = b0 + 32'd65;
    chk_eq("t4_bits", bit_cnt_o, b1);
    cyc = 0;
    while (!locked_o && cyc < 200) begin
      prbs_smp(1'b0);
      cyc++;
    end
    chk_eq("t4_relock", locked_o, 1);
    chk_eq("t4_relock_time", cyc, 64);
    chk_eq("t4_relock_lag", lag_o, 37);
    chk_eq("t4_bits_held", bit_cnt_o, b1);

    // Clear concurrent with an enabled sample while locked
    clear_i = 1'b1;
    prbs_smp(1'b0);
    clear_i = 1'b0;
    chk_eq("t6_clr_locked", locked_o, 0);
    chk_eq("t6_clr_lag", lag_o, 0);
    chk_eq("t6_clr_bits", bit_cnt_o, 0);
    chk_eq("t6_clr_errs", err_cnt_o, 0);
    chk_eq("t6_clr_loss", loss_cnt_o, 0);

    // Enable on one cycle in three, garbage on the idle cycles
    prbs_reset();
    cyc = 0;
    while (!locked_o && cyc < 3 * (38 * 64 + 2) + 10) begin
      if (cyc % 3 == 0) prbs_smp(1'b0);
      else step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cyc++;
    end
    chk_eq("t5_lock", locked_o, 1);
    chk_eq("t5_lag", lag_o, 37);
    chk_eq("t5_samples", smp_n, 2433);
    b0 = bit_cnt_o;
    step(1'b0, 1'b1, 1'b0);
    chk_eq("t5_frozen", bit_cnt_o, b0);
    for (int k = 0; k < 89; k++) begin
      if (k % 3 == 1) prbs_smp(1'b0);
      else step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    chk_eq("t5_bits", bit_cnt_o - b0, 30);
    chk_eq("t5_errs", err_cnt_o, 0);
    chk_eq("t5_locked", locked_o, 1);

    // Asynchronous reset mid-window
    for (int i = 0; i < 20; i++) prbs_smp(1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_eq("t7_locked", locked_o, 0);
    chk_eq("t7_lag", lag_o, 0);
    chk_eq("t7_bits", bit_cnt_o, 0);
    chk_eq("t7_errs", err_cnt_o, 0);
    chk_eq("t7_loss", loss_cnt_o, 0);
    #10;
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/viterbi_ber_monitor.md
Name: viterbi_ber_monitor

Overview:
- In-line bit-error-rate monitor that sits directly downstream of viterbi_tx_rx.
- Inputs: the original data stream (same as encoder_i) and the decoded stream (decoder_o).
- Searches for the decoder's end-to-end latency automatically, locks onto it, then counts compared bits and bit errors.
- Replaces the bench-side history-array scoreboard with synthesizable hardware, so link quality can be read on silicon.

Parameters:
- LAG_W, 12: width of lag; max searchable lag = 2**LAG_W-1 samples; delay buffer depth = 2**LAG_W bits.
- WIN, 64: samples per evaluation window.
- LOCK_ERR, 2: window errors <= LOCK_ERR at the end of a SEARCH window -> lock.
- UNLOCK_ERR, 8: window errors > UNLOCK_ERR while LOCKED -> lose lock.
- CNT_W, 32: width of the bit and error counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- enable_i  in  1  one sample of ref_i/dec_i is valid this cycle.
- ref_i  in  1  reference (original) data bit.
- dec_i  in  1  decoded data bit.
- clear_i  in  1  synchronous clear: counters, fill and FSM back to start.
- locked_o  out  1  alignment found.
- lag_o  out  LAG_W  current candidate/locked lag in samples.
- bit_cnt_o  out  CNT_W  compared bits while locked.
- err_cnt_o  out  CNT_W  mismatches while locked.
- loss_cnt_o  out  8  lock-loss events, saturating.

Behaviour:
- Reset (rst=0, async): all outputs 0; FSM=SEARCH; write pointer, fill count and window counters 0. Buffer contents need not be reset.
- Sample n is defined only by cycles with enable_i=1; enable_i=0 freezes all state.
- Delay buffer: circular 2**LAG_W x 1. On each enabled sample, ref_i is written at wp and wp increments, wrapping mod 2**LAG_W.
- Lag L compares dec_i(n) with ref_i(n-L). L=0 compares the current ref_i directly.
- Compare pipeline: the delayed-ref read and dec_i are registered. The mismatch flag is therefore evaluated 1 enabled-sample later (1 cycle latency at continuous enable).
- fill: saturating count of samples written, max 2**LAG_W. Sample n counts toward a window only if fill > L at its write time; earlier samples are ignored entirely.
- FSM SEARCH:
  - Each window accumulates WIN counted samples at candidate lag_o.
  - Window end with errors <= LOCK_ERR -> LOCKED; locked_o=1 on the cycle after the final compare.
  - Otherwise lag_o+1 (wraps from 2**LAG_W-1 to 0) and the window counters restart.
- FSM LOCKED:
  - Every counted sample increments bit_cnt_o; each mismatch also increments err_cnt_o. Both saturate at all-ones.
  - Windows are still evaluated. Window errors > UNLOCK_ERR -> SEARCH, locked_o=0, loss_cnt_o+1 (saturating at 255), lag_o unchanged so the same lag is retried first.
  - bit_cnt_o and err_cnt_o hold their values (are not cleared) on lock loss.
- Windows are non-overlapping and restart on every state change.
- clear_i=1: next edge sets FSM=SEARCH, lag_o=0, fill=0, all counters 0, locked_o=0; loss_cnt_o is also cleared.
- clear_i with enable_i in the same cycle: clear wins and the sample is discarded.
- Reset mid-window: async, returns to the reset state immediately; partial windows are discarded.
- Error count within a window saturates at UNLOCK_ERR+1.

Decomposition:
- viterbi_pkg holds:
  - typedef enum logic {SEARCH, LOCKED} ber_state_t
  - default constants BER_LAG_W, BER_WIN, BER_LOCK_ERR, BER_UNLOCK_ERR
- One sub-module, ber_delay_ram:
  - Parameterized circular bit buffer with write pointer, registered read at (wp-L).
  - Synchronous write and registered read, with no reset on the array.
- The top level holds the FSM, fill and window counters, and statistics counters.

Test Plan:
- Reset, then continuous enable with random ref_i and dec_i=ref_i -> lock at lag_o=0 after 64 samples plus 1 cycle; err_cnt_o=0; bit_cnt_o tracks samples.
- PRBS-7 ref_i with dec_i = ref_i delayed 37 samples (continuous enable) -> lag_o steps 0..37; locked_o=1, lag_o=37 within 38*64+2 cycles; err_cnt_o stays 0.
- After lock at lag 37, flip one dec_i bit every 100 samples for 1000 samples -> locked_o stays 1, err_cnt_o=10, bit_cnt_o advances by 1000.
- After lock, flip 9 consecutive dec_i bits in one window -> locked_o=0 and loss_cnt_o=1 at the window end; relock at lag_o=37 one clean window later.
- Toggle enable_i 1-of-3 cycles with a 37-sample lag -> same lock lag; counters advance only on enabled samples.
- Assert clear_i concurrently with enable_i while locked -> next cycle all counters 0, lag_o=0, locked_o=0. Also pulse rst low mid-window -> outputs 0 immediately (async).
